// File: rtl/ahb_sram_slave_if.sv
// Slave-side AHB signal bundle between ahb_fabric and ahb_sram_slave.
interface ahb_sram_slave_if;
    logic        sHSEL;
    logic [31:0] sHADDR;
    logic [1:0]  sHTRANS;
    logic        sHWRITE;
    logic [2:0]  sHSIZE;
    logic [2:0]  sHBURST;
    logic [31:0] sHWDATA;
    logic        sHREADYin;
    logic [31:0] sHRDATA;
    logic        sHREADY;
    logic [1:0]  sHRESP;

    modport slave (
        input  sHSEL, sHADDR, sHTRANS, sHWRITE, sHSIZE, sHBURST, sHWDATA, sHREADYin,
        output sHRDATA, sHREADY, sHRESP
    );

    modport master (
        output sHSEL, sHADDR, sHTRANS, sHWRITE, sHSIZE, sHBURST, sHWDATA, sHREADYin,
        input  sHRDATA, sHREADY, sHRESP
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB slave terminating one fabric port with a word-organised SRAM and programmable wait states.
// Define AHB_SLV_ERR_EN to compile in size/alignment/range checks and the two-cycle ERROR response.
//
// state | meaning
// OKAY  | data phase complete or no data phase pending, HREADY=1
// WAIT  | inserting wait states, HREADY=0
// ERR1  | first ERROR cycle, HREADY=0
// ERR2  | second ERROR cycle, HREADY=1
module ahb_sram_slave #(
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic            HCLK,
    input  logic            HRESET,
    ahb_sram_slave_if.slave bus
);
    localparam int         AW = $clog2(MEM_DEPTH);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

`ifdef AHB_SLV_ERR_EN
    typedef enum logic [1:0] {ST_OKAY, ST_WAIT, ST_ERR1, ST_ERR2} state_e;
`else
    typedef enum logic [1:0] {ST_OKAY, ST_WAIT} state_e;
`endif

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [1:0]    trans_q, trans_d;
    logic          write_q, write_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   mem [MEM_DEPTH];

    logic          ready, accept, active, wr_en, rd_load, fwd;
    logic [AW-1:0] a_idx, rd_idx;
    logic [3:0]    a_be;
    logic [31:0]   rd_word, wmask;
    logic          unused_bits;

    assign unused_bits = ^{bus.sHBURST, bus.sHADDR};

`ifdef AHB_SLV_ERR_EN
    logic addr_err;
    assign ready      = (state_q == ST_OKAY) || (state_q == ST_ERR2);
    assign bus.sHRESP = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? 2'b01 : 2'b00;
    assign addr_err   = (bus.sHSIZE > 3'd2)
                     || ((bus.sHSIZE == 3'd1) && bus.sHADDR[0])
                     || ((bus.sHSIZE == 3'd2) && (bus.sHADDR[1:0] != 2'b00))
                     || ((bus.sHADDR >> (AW + 2)) != 32'd0);
`else
    assign ready      = (state_q == ST_OKAY);
    assign bus.sHRESP = 2'b00;
`endif

    assign bus.sHREADY = ready;
    assign bus.sHRDATA = rdata_q;

    assign accept = bus.sHSEL && bus.sHREADYin && ready;
    assign active = accept && bus.sHTRANS[1];
    assign a_idx  = bus.sHADDR[AW+1:2];
    // a data phase ends with a memory update only from OKAY; ERR2 never writes
    assign wr_en  = (state_q == ST_OKAY) && trans_q[1] && write_q;
    assign wmask  = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};

    always_comb begin
        case (bus.sHSIZE)
            3'd0:    a_be = 4'b0001 << bus.sHADDR[1:0];
            3'd1:    a_be = bus.sHADDR[1] ? 4'b1100 : 4'b0011;
            default: a_be = 4'b1111;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        trans_d = trans_q;
        write_d = write_q;
        idx_d   = idx_q;
        be_d    = be_q;
        rd_load = 1'b0;
        rd_idx  = idx_q;

        case (state_q)
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_OKAY;
                    rd_load = !write_q;
                end
            end
`ifdef AHB_SLV_ERR_EN
            ST_ERR1: state_d = ST_ERR2;
`endif
            default: ;
        endcase

        if (ready) begin
            state_d = ST_OKAY;
            trans_d = 2'b00;
            if (accept) begin
                trans_d = bus.sHTRANS;
                write_d = bus.sHWRITE;
                idx_d   = a_idx;
                be_d    = a_be;
                if (active) begin
`ifdef AHB_SLV_ERR_EN
                    if (addr_err) state_d = ST_ERR1;
                    else
`endif
                    if (WS != 4'd0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WS;
                    end else begin
                        rd_load = !bus.sHWRITE;
                        rd_idx  = a_idx;
                    end
                end
            end
        end
    end

    // a zero-wait read right behind a write to the same word sees the write's lanes merged in
    assign rd_word = mem[rd_idx];
    assign fwd     = wr_en && (idx_q == rd_idx);

    always_comb begin
        rdata_d = rdata_q;
        if (rd_load) rdata_d = fwd ? ((rd_word & ~wmask) | (bus.sHWDATA & wmask)) : rd_word;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_OKAY;
            cnt_q   <= 4'd0;
            trans_q <= 2'b00;
            write_q <= 1'b0;
            idx_q   <= '0;
            be_q    <= 4'd0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trans_q <= trans_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESET && wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) mem[idx_q][8*b +: 8] <= bus.sHWDATA[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench: two slaves (zero and two wait states) driven by a pipelined AHB master model.
module tb_ahb_sram_slave;
    localparam int MD  = 64;
    localparam int WS0 = 0;
    localparam int WS1 = 2;

    typedef struct packed {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst     [2];
    logic        sel_v   [2];
    logic [31:0] addr_v  [2];
    logic [1:0]  trans_v [2];
    logic        wr_v    [2];
    logic [2:0]  size_v  [2];
    logic [31:0] wdata_v [2];
    logic        rdy_w   [2];
    logic [1:0]  resp_w  [2];
    logic [31:0] rdata_w [2];

    ahb_sram_slave_if bus0();
    ahb_sram_slave_if bus1();

    assign bus0.sHSEL = sel_v[0];   assign bus1.sHSEL = sel_v[1];
    assign bus0.sHADDR = addr_v[0]; assign bus1.sHADDR = addr_v[1];
    assign bus0.sHTRANS = trans_v[0]; assign bus1.sHTRANS = trans_v[1];
    assign bus0.sHWRITE = wr_v[0];  assign bus1.sHWRITE = wr_v[1];
    assign bus0.sHSIZE = size_v[0]; assign bus1.sHSIZE = size_v[1];
    assign bus0.sHBURST = 3'b011;   assign bus1.sHBURST = 3'b001;
    assign bus0.sHWDATA = wdata_v[0]; assign bus1.sHWDATA = wdata_v[1];
    assign bus0.sHREADYin = bus0.sHREADY; assign bus1.sHREADYin = bus1.sHREADY;
    assign rdy_w[0] = bus0.sHREADY; assign rdy_w[1] = bus1.sHREADY;
    assign resp_w[0] = bus0.sHRESP; assign resp_w[1] = bus1.sHRESP;
    assign rdata_w[0] = bus0.sHRDATA; assign rdata_w[1] = bus1.sHRDATA;

    ahb_sram_slave #(.MEM_DEPTH(MD), .WAIT_STATES(WS0)) u_dut0 (.HCLK(clk), .HRESET(rst[0]), .bus(bus0));
    ahb_sram_slave #(.MEM_DEPTH(MD), .WAIT_STATES(WS1)) u_dut1 (.HCLK(clk), .HRESET(rst[1]), .bus(bus1));

    xfer_t       xq[$];
    logic [31:0] o_rdata [128];
    logic [1:0]  o_resp  [128];
    logic [1:0]  o_resp0 [128];
    int          o_waits [128];
    int          o_cycles;
    logic [31:0] e_rdata [128];
    logic        e_chk   [128];
    logic [1:0]  e_resp  [128];
    int          e_waits [128];
    logic [31:0] ref_mem [2][MD];
    logic [3:0]  ref_kn  [2][MD];
    logic [31:0] last_rd [2];
    logic        last_kn [2];
    int          n_pass, n_total;

    function automatic int ws_of(input int d);
        return (d == 0) ? WS0 : WS1;
    endfunction

    task automatic add(input logic sel, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
        xfer_t x;
        x.sel = sel; x.trans = tr; x.wr = wr; x.size = sz; x.addr = a; x.wdata = wd;
        xq.push_back(x);
    endtask

    task automatic drive_x(input int d, input xfer_t x);
        sel_v[d] = x.sel; trans_v[d] = x.trans; wr_v[d] = x.wr; size_v[d] = x.size; addr_v[d] = x.addr;
    endtask

    task automatic drive_idle(input int d);
        sel_v[d] = 1'b0; trans_v[d] = 2'b00; wr_v[d] = 1'b0; size_v[d] = 3'd2; addr_v[d] = 32'h0;
    endtask

    // Reference: transfers take effect strictly in bus order, so a read sees every earlier write.
    task automatic model_run(input int d);
        for (int k = 0; k < xq.size(); k++) begin
            xfer_t x;
            int idx, nb, base;
            bit err;
            x = xq[k];
            e_chk[k] = 1'b0; e_waits[k] = 0; e_resp[k] = 2'b00; e_rdata[k] = 32'h0;
            if (x.sel && x.trans[1]) begin
                idx = int'(x.addr >> 2);
                err = 1'b0;
`ifdef AHB_SLV_ERR_EN
                err = (x.size > 3'd2) || (x.size == 3'd1 && x.addr[0]) ||
                      (x.size == 3'd2 && x.addr[1:0] != 2'b00) || (idx >= MD);
`else
                idx = idx % MD;
`endif
                if (err) begin
                    e_waits[k] = 1;
                    e_resp[k]  = 2'b01;
                    if (!x.wr) begin e_chk[k] = last_kn[d]; e_rdata[k] = last_rd[d]; end
                end else begin
                    e_waits[k] = ws_of(d);
                    nb   = (x.size == 3'd0) ? 1 : (x.size == 3'd1) ? 2 : 4;
                    base = int'(x.addr[1:0]) / nb * nb;
                    if (x.wr) begin
                        for (int b = base; b < base + nb; b++) begin
                            ref_mem[d][idx][8*b +: 8] = x.wdata[8*b +: 8];
                            ref_kn[d][idx][b] = 1'b1;
                        end
                    end else begin
                        e_rdata[k] = ref_mem[d][idx];
                        e_chk[k]   = (ref_kn[d][idx] == 4'hF);
                        last_rd[d] = e_rdata[k];
                        last_kn[d] = e_chk[k];
                    end
                end
            end
        end
    endtask

    // Pipelined master: next address phase is presented while the previous data phase runs.
    task automatic run_xfers(input int d);
        int n, nxt, dpi, ndp, cyc;
        logic r;
        n = xq.size(); nxt = 0; dpi = -1; cyc = 0;
        if (n > 0) drive_x(d, xq[0]);
        while ((nxt < n || dpi >= 0) && cyc < 400) begin
            @(negedge clk);
            cyc++;
            r = rdy_w[d];
            if (dpi >= 0) begin
                if (o_waits[dpi] == 0) o_resp0[dpi] = resp_w[d];
                if (r) begin o_rdata[dpi] = rdata_w[d]; o_resp[dpi] = resp_w[d]; end
                else o_waits[dpi]++;
            end
            ndp = -1;
            if (r && nxt < n) begin ndp = nxt; nxt++; end
            @(posedge clk); #1;
            if (r) begin
                dpi = ndp;
                if (dpi >= 0) begin o_waits[dpi] = 0; wdata_v[d] = xq[dpi].wdata; end
                if (nxt < n) drive_x(d, xq[nxt]); else drive_idle(d);
            end
        end
        o_cycles = cyc;
        if (nxt < n || dpi >= 0) begin
            n_total++;
            $display("FAIL run_timeout dut%0d: got %0d cycles without completion, need fewer than 400", d, cyc);
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin drive_idle(d); wdata_v[d] = 32'h0; rst[d] = 1'b1; end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) rst[d] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (rdy_w[d] !== 1'b1) $display("FAIL reset_ready dut%0d: got %b want 1", d, rdy_w[d]); else n_pass++;
            n_total++;
            if (resp_w[d] !== 2'b00) $display("FAIL reset_resp dut%0d: got %b want 00", d, resp_w[d]); else n_pass++;
            n_total++;
            if (rdata_w[d] !== 32'h0) $display("FAIL reset_rdata dut%0d: got %h want 0", d, rdata_w[d]); else n_pass++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_roundtrip();
        for (int d = 0; d < 2; d++) begin
            xq.delete();
            add(1, 2'b10, 1, 3'd2, 32'h10, 32'hDEAD_BEEF);
            add(1, 2'b10, 0, 3'd2, 32'h10, 32'h0);
            model_run(d); run_xfers(d);
            n_total++;
            if (o_rdata[1] !== 32'hDEAD_BEEF || o_waits[1] !== ws_of(d) || o_resp[1] !== 2'b00)
                $display("FAIL roundtrip dut%0d: got data %h waits %0d resp %b want DEADBEEF %0d 00",
                         d, o_rdata[1], o_waits[1], o_resp[1], ws_of(d));
            else n_pass++;
            for (int k = 0; k < xq.size(); k++) begin
                n_total++;
                if (o_waits[k] !== e_waits[k]) $display("FAIL rt_waits dut%0d[%0d]: got %0d want %0d", d, k, o_waits[k], e_waits[k]); else n_pass++;
            end
        end
    endtask

    task automatic test_byte_forward();
        for (int d = 0; d < 2; d++) begin
            xq.delete();
            add(1, 2'b10, 1, 3'd2, 32'h20, 32'h1122_3344);
            add(1, 2'b10, 1, 3'd0, 32'h23, 32'hAA00_0000);
            add(1, 2'b10, 0, 3'd2, 32'h20, 32'h0);
            add(1, 2'b10, 1, 3'd1, 32'h22, 32'h5566_0000);
            add(1, 2'b10, 0, 3'd2, 32'h20, 32'h0);
            model_run(d); run_xfers(d);
            n_total++;
            if (o_rdata[2] !== 32'hAA22_3344) $display("FAIL byte_fwd dut%0d: got %h want AA223344", d, o_rdata[2]); else n_pass++;
            n_total++;
            if (o_rdata[4] !== 32'h5566_3344) $display("FAIL half_fwd dut%0d: got %h want 55663344", d, o_rdata[4]); else n_pass++;
            for (int k = 0; k < xq.size(); k++) begin
                n_total++;
                if (o_waits[k] !== e_waits[k] || o_resp[k] !== e_resp[k])
                    $display("FAIL bf_handshake dut%0d[%0d]: got waits %0d resp %b want %0d %b", d, k, o_waits[k], o_resp[k], e_waits[k], e_resp[k]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        xq.delete();
        for (int k = 0; k < 4; k++) add(1, (k == 0) ? 2'b10 : 2'b11, 1, 3'd2, 32'h40 + 32'(4*k), 32'(k + 1));
        for (int k = 0; k < 4; k++) add(1, (k == 0) ? 2'b10 : 2'b11, 0, 3'd2, 32'h40 + 32'(4*k), 32'h0);
        model_run(0); run_xfers(0);
        n_total++;
        if (o_cycles !== 9) $display("FAIL b2b_cycles: got %0d want 9", o_cycles); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            n_total++;
            if (o_waits[k] !== 0) $display("FAIL b2b_ready[%0d]: got %0d wait cycles want 0", k, o_waits[k]); else n_pass++;
        end
        for (int k = 4; k < 8; k++) begin
            n_total++;
            if (o_rdata[k] !== 32'(k - 3)) $display("FAIL b2b_rdata[%0d]: got %h want %h", k, o_rdata[k], 32'(k - 3)); else n_pass++;
        end
    endtask

    task automatic test_busy_idle();
        for (int d = 0; d < 2; d++) begin
            xq.delete();
            add(1, 2'b10, 1, 3'd2, 32'h50, 32'hA5A5_0001);
            add(1, 2'b01, 1, 3'd2, 32'h54, 32'hFFFF_FFFF);
            add(1, 2'b11, 1, 3'd2, 32'h54, 32'h5A5A_0002);
            add(1, 2'b00, 1, 3'd2, 32'h50, 32'hFFFF_FFFF);
            add(0, 2'b10, 1, 3'd2, 32'h54, 32'hEEEE_EEEE);
            add(1, 2'b10, 0, 3'd2, 32'h50, 32'h0);
            add(1, 2'b11, 0, 3'd2, 32'h54, 32'h0);
            model_run(d); run_xfers(d);
            n_total++;
            if (o_rdata[5] !== 32'hA5A5_0001 || o_rdata[6] !== 32'h5A5A_0002)
                $display("FAIL busy_idle_mem dut%0d: got %h %h want A5A50001 5A5A0002", d, o_rdata[5], o_rdata[6]);
            else n_pass++;
            for (int k = 0; k < xq.size(); k++) begin
                n_total++;
                if (o_waits[k] !== e_waits[k] || o_resp[k] !== e_resp[k])
                    $display("FAIL busy_idle_hs dut%0d[%0d]: got waits %0d resp %b want %0d %b", d, k, o_waits[k], o_resp[k], e_waits[k], e_resp[k]);
                else n_pass++;
            end
        end
    endtask

`ifdef AHB_SLV_ERR_EN
    task automatic test_error();
        for (int d = 0; d < 2; d++) begin
            xq.delete();
            add(1, 2'b10, 1, 3'd2, 32'h00, 32'h0102_0304);
            add(1, 2'b10, 1, 3'd2, 32'h02, 32'hFFFF_FFFF);
            add(1, 2'b10, 0, 3'd2, 32'h00, 32'h0);
            add(1, 2'b10, 0, 3'd2, 32'(MD * 4), 32'h0);
            add(1, 2'b10, 0, 3'd3, 32'h08, 32'h0);
            add(1, 2'b10, 1, 3'd1, 32'h01, 32'hFFFF_FFFF);
            add(1, 2'b10, 0, 3'd2, 32'h00, 32'h0);
            model_run(d); run_xfers(d);
            n_total++;
            if (o_resp0[1] !== 2'b01 || o_resp[1] !== 2'b01 || o_waits[1] !== 1)
                $display("FAIL err_misalign dut%0d: got resp %b/%b waits %0d want 01/01 1", d, o_resp0[1], o_resp[1], o_waits[1]);
            else n_pass++;
            n_total++;
            if (o_rdata[6] !== 32'h0102_0304) $display("FAIL err_nowrite dut%0d: got %h want 01020304", d, o_rdata[6]); else n_pass++;
            for (int k = 0; k < xq.size(); k++) begin
                n_total++;
                if (o_waits[k] !== e_waits[k] || o_resp0[k] !== e_resp[k] || o_resp[k] !== e_resp[k])
                    $display("FAIL err_hs dut%0d[%0d]: got waits %0d resp %b/%b want %0d %b", d, k, o_waits[k], o_resp0[k], o_resp[k], e_waits[k], e_resp[k]);
                else n_pass++;
                if (e_chk[k]) begin
                    n_total++;
                    if (o_rdata[k] !== e_rdata[k]) $display("FAIL err_rdata dut%0d[%0d]: got %h want %h", d, k, o_rdata[k], e_rdata[k]); else n_pass++;
                end
            end
        end
    endtask
`else
    task automatic test_wrap();
        for (int d = 0; d < 2; d++) begin
            xq.delete();
            add(1, 2'b10, 1, 3'd2, 32'((MD + 5) * 4), 32'hCAFE_0005);
            add(1, 2'b10, 0, 3'd2, 32'h14, 32'h0);
            add(1, 2'b10, 1, 3'd3, 32'h18, 32'h7777_7777);
            add(1, 2'b10, 0, 3'd2, 32'h18, 32'h0);
            add(1, 2'b10, 1, 3'd2, 32'h1A, 32'h1357_9BDF);
            add(1, 2'b10, 0, 3'd2, 32'h18, 32'h0);
            model_run(d); run_xfers(d);
            n_total++;
            if (o_rdata[1] !== 32'hCAFE_0005) $display("FAIL wrap dut%0d: got %h want CAFE0005", d, o_rdata[1]); else n_pass++;
            for (int k = 0; k < xq.size(); k++) begin
                n_total++;
                if (o_waits[k] !== e_waits[k] || o_resp[k] !== e_resp[k])
                    $display("FAIL wrap_hs dut%0d[%0d]: got waits %0d resp %b want %0d %b", d, k, o_waits[k], o_resp[k], e_waits[k], e_resp[k]);
                else n_pass++;
                if (e_chk[k]) begin
                    n_total++;
                    if (o_rdata[k] !== e_rdata[k]) $display("FAIL wrap_rdata dut%0d[%0d]: got %h want %h", d, k, o_rdata[k], e_rdata[k]); else n_pass++;
                end
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int d = 0; d < 2; d++) begin
            xq.delete();
            for (int w = 0; w < 16; w++) add(1, 2'b10, 1, 3'd2, 32'(4 * w), $urandom);
            for (int i = 0; i < 48; i++) begin
                int sz, a, t;
                logic [1:0] tr;
                sz = $urandom_range(0, 2);
                a  = $urandom_range(0, 63);
                a  = a / (1 << sz) * (1 << sz);
                t  = $urandom_range(0, 9);
                tr = (t < 1) ? 2'b00 : (t < 2) ? 2'b01 : (t < 6) ? 2'b10 : 2'b11;
                add($urandom_range(0, 9) != 0, tr, 1'($urandom_range(0, 1)), 3'(sz), 32'(a), $urandom);
            end
            model_run(d); run_xfers(d);
            for (int k = 0; k < xq.size(); k++) begin
                n_total++;
                if (o_waits[k] !== e_waits[k] || o_resp[k] !== e_resp[k])
                    $display("FAIL rand_hs dut%0d[%0d]: got waits %0d resp %b want %0d %b", d, k, o_waits[k], o_resp[k], e_waits[k], e_resp[k]);
                else n_pass++;
                if (e_chk[k]) begin
                    n_total++;
                    if (o_rdata[k] !== e_rdata[k]) $display("FAIL rand_rdata dut%0d[%0d]: got %h want %h", d, k, o_rdata[k], e_rdata[k]); else n_pass++;
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        xfer_t x;
        xq.delete();
        add(1, 2'b10, 1, 3'd2, 32'h30, 32'h0BAD_F00D);
        add(1, 2'b10, 0, 3'd2, 32'h30, 32'h0);
        model_run(1); run_xfers(1);
        n_total++;
        if (o_rdata[1] !== 32'h0BAD_F00D) $display("FAIL rstmid_preset: got %h want 0BADF00D", o_rdata[1]); else n_pass++;
        x.sel = 1; x.trans = 2'b10; x.wr = 1; x.size = 3'd2; x.addr = 32'h30; x.wdata = 32'h1234_5678;
        drive_x(1, x);
        @(posedge clk); #1;
        wdata_v[1] = x.wdata;
        drive_idle(1);
        @(negedge clk);
        n_total++;
        if (rdy_w[1] !== 1'b0) $display("FAIL rstmid_wait: got ready %b want 0", rdy_w[1]); else n_pass++;
        rst[1] = 1'b1;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        last_rd[1] = 32'h0; last_kn[1] = 1'b1;
        @(negedge clk);
        n_total++;
        if (rdy_w[1] !== 1'b1 || resp_w[1] !== 2'b00 || rdata_w[1] !== 32'h0)
            $display("FAIL rstmid_outputs: got ready %b resp %b rdata %h want 1 00 0", rdy_w[1], resp_w[1], rdata_w[1]);
        else n_pass++;
        @(posedge clk); #1;
        xq.delete();
        add(1, 2'b10, 0, 3'd2, 32'h30, 32'h0);
        model_run(1); run_xfers(1);
        n_total++;
        if (o_rdata[0] !== e_rdata[0] || o_rdata[0] !== 32'h0BAD_F00D)
            $display("FAIL rstmid_discard: got %h want 0BADF00D", o_rdata[0]);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < MD; i++) begin ref_mem[d][i] = 32'h0; ref_kn[d][i] = 4'h0; end
            last_rd[d] = 32'h0;
            last_kn[d] = 1'b1;
        end
        test_reset();
        test_roundtrip();
        test_byte_forward();
        test_back_to_back();
        test_busy_idle();
`ifdef AHB_SLV_ERR_EN
        test_error();
`else
        test_wrap();
`endif
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB slave that terminates one slave port of `ahb_fabric` with a word-organised on-chip SRAM. It is the responder end of the bus: it samples the address phase the fabric broadcasts and answers the data phase on sHRDATA, sHREADY and sHRESP. It supports programmable wait states, byte, halfword and word writes, and a two-cycle ERROR response. The NN calculator uses it as the scratch and weight store behind fabric slave ports s0 to s3.

## Interface
- MEM_DEPTH, 1024, number of 32-bit words; power of two; index = sHADDR[log2(MEM_DEPTH)+1:2]
- WAIT_STATES, 1, data-phase wait cycles inserted per NONSEQ/SEQ transfer; range 0 to 15

- HCLK  in  1  bus clock, all state on rising edge
- HRESET  in  1  reset, synchronous, active-high
- sHSEL  in  1  slave select from fabric decoder
- sHADDR  in  32  transfer address
- sHTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- sHWRITE  in  1  1 = write
- sHSIZE  in  3  0 byte, 1 halfword, 2 word
- sHBURST  in  3  burst type; informational only, each beat is addressed explicitly
- sHWDATA  in  32  write data, valid in the data phase
- sHREADYin  in  1  bus-wide HREADY from fabric
- sHRDATA  out  32  read data
- sHREADY  out  1  this slave's ready
- sHRESP  out  2  00 OKAY, 01 ERROR

## Operation
- **Address-phase accept.** An address phase is accepted on a rising edge when sHSEL=1 and sHREADYin=1. On accept the block registers address, write, size and trans.
- **Active transfer.** A transfer is active only when trans is NONSEQ or SEQ.
- **No-op accepts.** IDLE, BUSY, or sHSEL=0 produce a zero-wait OKAY data phase with no memory access.
- **State machine.**
  - OKAY: sHREADY=1, sHRESP=00.
  - WAIT: sHREADY=0, sHRESP=00. A counter loads WAIT_STATES on accept and decrements each cycle.
  - ERR1: sHREADY=0, sHRESP=01.
  - ERR2: sHREADY=1, sHRESP=01.
- **Transitions.**
  - Active accept with no error: goes to WAIT if WAIT_STATES>0, otherwise completes in OKAY next cycle.
  - WAIT: moves to OKAY when the counter reaches 1.
  - Accept with error: goes to ERR1, then ERR2. From ERR2 the next state is set by whatever address phase is accepted in ERR2.
- **Write lanes.**
  - Lanes are little-endian.
  - size 0: lane sHADDR[1:0].
  - size 1: lanes {a[1],0} and {a[1],1}.
  - size 2: all four lanes.
  - Memory is updated with sHWDATA lanes on the edge ending the data phase, i.e. the edge at which sHREADY=1.
- **Read data.**
  - Full word on sHRDATA, valid in the cycle sHREADY=1.
  - sHRDATA holds its last value otherwise.
  - The master extracts lanes.
- **Forwarding.** A read whose data phase immediately follows a write data phase to the same word returns the merged new data. This applies for any WAIT_STATES, including 0.
- **Error conditions** (only with the macro below): sHSIZE>2, misaligned address (halfword with a[0]=1, word with a[1:0]≠0), or word index ≥ MEM_DEPTH.
- **Errored transfers.** An errored write does not modify memory. An errored read leaves sHRDATA unchanged.
- **Reset.**
  - Reset mid-transfer aborts the transfer.
  - A pending write is discarded.
  - The state machine returns to OKAY.
  - Memory contents are not cleared.

## Timing
- **Reset values.** sHREADY=1, sHRESP=00, sHRDATA=32'h0. The registered trans is reset to IDLE.
- **Latency.** Address phase sampled at edge E0. The data phase occupies cycles E0+1 through E0+1+WAIT_STATES.
  - sHREADY=0 for the first WAIT_STATES cycles.
  - sHREADY=1 in the final cycle.
- **Pipelining.** A new address phase can be accepted on the same edge that completes the current data phase. Back-to-back zero-wait transfers sustain one per cycle.
- **Ignored inputs.** Address-phase inputs are ignored while sHREADYin=0, including during this slave's own WAIT and ERR1 cycles.
- **Error response.** Exactly 2 cycles: sHRESP=01 in both, sHREADY 0 then 1.
- **Error vs wait states.** An error response ignores WAIT_STATES.
- **Outputs are registered.** sHREADY and sHRESP come from state. sHRDATA comes from a register loaded at the edge entering the final data-phase cycle.

## Configuration
- **AHB_SLV_ERR_EN defined:** error detection and the ERR1/ERR2 states are compiled in.
- **AHB_SLV_ERR_EN undefined:**
  - sHRESP is tied 00 and the ERR states are absent.
  - sHSIZE>2 is treated as word.
  - Misaligned low address bits are ignored for lane selection above the access size.
  - The word index wraps modulo MEM_DEPTH.

## Test plan
- **Reset and word round-trip.** Reset, WAIT_STATES=1; NONSEQ word write 0x0000_0010 ← 0xDEAD_BEEF, then NONSEQ read 0x10 → sHREADY low 1 cycle, then high with sHRDATA=0xDEADBEEF, sHRESP=00.
- **Byte write and forwarding.** Word 0x20 preset 0x1122_3344; byte write 0x23 ← 0xAA in lane 3, then an immediate read of 0x20 with WAIT_STATES=0 → 0xAA22_3344 via forwarding.
- **Zero-wait burst.** INCR4 with WAIT_STATES=0 writing 1,2,3,4 to 0x40 to 0x4C, then INCR4 read → sHREADY constant 1; reads return 1,2,3,4 in consecutive cycles.
- **BUSY and IDLE.** BUSY inserted mid-burst, and IDLE with sHSEL=1 → zero-wait OKAY, memory unchanged.
- **Error response (macro defined).**
  - Word write to 0x02 → two-cycle ERROR (sHREADY 0 then 1, sHRESP 01 both); word 0 unchanged.
  - Read at index MEM_DEPTH → same ERROR response.
- **Reset mid-transfer.** Assert HRESET during the WAIT cycle of a write to 0x30 → next cycle sHREADY=1, sHRESP=00, sHRDATA=0; read 0x30 returns its old value.
